// File: rtl/demux_pkg.sv
// Shared constants and helpers for the one-to-many stream demultiplexer.
package demux_pkg;

  localparam int DEF_WIDTH    = 32'd8;
  localparam int DEF_CHANNELS = 32'd4;
  localparam int ERR_CNT_W    = 32'd8;

  // Ceiling log2 for parameter checks; returns 0 for n <= 1.
  function automatic int clog2(input int n);
    int r;
    r = 32'd0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) begin
        r = i + 32'd1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output holding register: loads a word, drains on handshake and
// shows all-zero data whenever it is empty.
module demux_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Next-state: a load wins over a drain so drain-and-refill keeps valid high.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
      data_d  = '0;
    end else begin
      valid_d = valid_q;
      data_d  = data_q;
    end
  end

  // Slot state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/demux_stream.sv
// Stream demultiplexer: routes each accepted word to one channel slot (or all
// slots in broadcast); out-of-range unicast words are dropped and counted.
module demux_stream
  import demux_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic                      in_bcast,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ready,
  output logic                      err_sel,
  output logic [ERR_CNT_W-1:0]      err_cnt
);

  if (SEL_W != clog2(CHANNELS) || WIDTH < 1 || WIDTH > 64 ||
      CHANNELS < 2 || CHANNELS > 16) begin : g_bad_params
    $error("demux_stream: illegal WIDTH/CHANNELS/SEL_W combination");
  end

  logic [CHANNELS-1:0]  sel_hit;
  logic [CHANNELS-1:0]  slot_free;
  logic [CHANNELS-1:0]  load;
  logic                 sel_in_range;
  logic                 accept;
  logic                 err_sel_q, err_sel_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  // One-hot select decode; no bit set means the index is out of range.
  always_comb begin
    sel_hit = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (in_sel == SEL_W'(c)) begin
        sel_hit[c] = 1'b1;
      end else begin
        sel_hit[c] = 1'b0;
      end
    end
  end

  assign slot_free    = ~out_valid | out_ready;
  assign sel_in_range = |sel_hit;

  // Ready decode; deliberately independent of in_valid.
  always_comb begin
    in_ready = 1'b0;
    if (!rst_n) begin
      in_ready = 1'b0;
    end else if (in_bcast) begin
      in_ready = &slot_free;
    end else if (!sel_in_range) begin
      in_ready = 1'b1;
    end else begin
      in_ready = |(sel_hit & slot_free);
    end
  end

  assign accept = in_valid & in_ready;
  assign load   = {CHANNELS{accept}} & ({CHANNELS{in_bcast}} | sel_hit);

  // Error pulse and saturating drop counter.
  always_comb begin
    err_sel_d = accept & ~in_bcast & ~sel_in_range;
    err_cnt_d = err_cnt_q;
    if (err_sel_d && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // Error state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sel_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      err_sel_q <= err_sel_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_sel = err_sel_q;
  assign err_cnt = err_cnt_q;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_slot
    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load[c]),
      .load_data (in_data),
      .ready     (out_ready[c]),
      .valid     (out_valid[c]),
      .data      (out_data[c*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_demux_stream.sv
// Directed self-checking bench for demux_stream with WIDTH=8, CHANNELS=3.
module tb_demux_stream;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic        in_bcast;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] out_data;
  logic [2:0]  out_valid;
  logic [2:0]  out_ready;
  logic        err_sel;
  logic [7:0]  err_cnt;

  int n_checks;
  int n_pass;

  demux_stream #(.WIDTH(8), .CHANNELS(3), .SEL_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_bcast  (in_bcast),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_sel   (err_sel),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    #2;
    n_checks++; if (out_valid !== 3'b000) $display("FAIL rst_valid got=%b exp=%b", out_valid, 3'b000); else n_pass++;
    n_checks++; if (out_data !== 24'h0) $display("FAIL rst_data got=%h exp=%h", out_data, 24'h0); else n_pass++;
    n_checks++; if (err_sel !== 1'b0 || err_cnt !== 8'd0) $display("FAIL rst_err got=%b/%0d exp=0/0", err_sel, err_cnt); else n_pass++;
    in_valid = 1'b1;
    in_sel   = 2'd0;
    in_data  = 8'hFF;
    #1;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready got=%b exp=0", in_ready); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 3'b000) $display("FAIL rst_hold_valid got=%b exp=000", out_valid); else n_pass++;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
  endtask

  task automatic test_unicast();
    @(negedge clk);
    out_ready = 3'b111;
    in_valid  = 1'b1; in_bcast = 1'b0; in_sel = 2'd1; in_data = 8'hA5;
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL uni_ready got=%b exp=1", in_ready); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 3'b010) $display("FAIL uni_valid got=%b exp=010", out_valid); else n_pass++;
    n_checks++; if (out_data !== 24'h00A500) $display("FAIL uni_data got=%h exp=00a500", out_data); else n_pass++;
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 3'b000 || out_data !== 24'h0) $display("FAIL uni_drain got=%b/%h exp=000/000000", out_valid, out_data); else n_pass++;
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    out_ready = 3'b110;
    in_valid  = 1'b1; in_sel = 2'd0; in_data = 8'h11;
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL bp_first_ready got=%b exp=1", in_ready); else n_pass++;
    @(posedge clk);
    @(negedge clk);
    in_data = 8'h22;
    #1;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_second_ready got=%b exp=0", in_ready); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 3'b001 || out_data !== 24'h000011) $display("FAIL bp_hold got=%b/%h exp=001/000011", out_valid, out_data); else n_pass++;
    @(negedge clk);
    out_ready = 3'b111;
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL bp_release_ready got=%b exp=1", in_ready); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 3'b001 || out_data !== 24'h000022) $display("FAIL bp_follow got=%b/%h exp=001/000022", out_valid, out_data); else n_pass++;
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 3'b000) $display("FAIL bp_empty got=%b exp=000", out_valid); else n_pass++;
  endtask

  task automatic test_broadcast();
    @(negedge clk);
    out_ready = 3'b011;
    in_valid  = 1'b1; in_bcast = 1'b0; in_sel = 2'd2; in_data = 8'h55;
    @(posedge clk);
    @(negedge clk);
    in_bcast = 1'b1; in_sel = 2'd0; in_data = 8'h3C;
    #1;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL bc_blocked_ready got=%b exp=0", in_ready); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 3'b100 || out_data !== 24'h550000) $display("FAIL bc_blocked_out got=%b/%h exp=100/550000", out_valid, out_data); else n_pass++;
    @(negedge clk);
    out_ready = 3'b111;
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL bc_release_ready got=%b exp=1", in_ready); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 3'b111 || out_data !== 24'h3C3C3C) $display("FAIL bc_all got=%b/%h exp=111/3c3c3c", out_valid, out_data); else n_pass++;
    n_checks++; if (err_sel !== 1'b0) $display("FAIL bc_no_err got=%b exp=0", err_sel); else n_pass++;
    @(negedge clk);
    in_valid = 1'b0; in_bcast = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 3'b000 || out_data !== 24'h0) $display("FAIL bc_drain got=%b/%h exp=000/000000", out_valid, out_data); else n_pass++;
  endtask

  task automatic test_out_of_range();
    int exp_cnt;
    int bad;
    bad = 0;
    @(negedge clk);
    out_ready = 3'b111;
    in_valid  = 1'b1; in_bcast = 1'b0; in_sel = 2'd3;
    for (int i = 0; i < 300; i++) begin
      in_data = 8'(i);
      #1;
      if (in_ready !== 1'b1 && bad < 4) begin
        $display("FAIL oor_ready word=%0d got=%b exp=1", i, in_ready);
        bad++;
      end
      @(posedge clk); #1;
      exp_cnt = (i + 1 > 255) ? 255 : i + 1;
      n_checks++;
      if (err_sel !== 1'b1 || err_cnt !== 8'(exp_cnt) || out_valid !== 3'b000)
        $display("FAIL oor_word%0d got=%b/%0d/%b exp=1/%0d/000", i, err_sel, err_cnt, out_valid, exp_cnt);
      else n_pass++;
      @(negedge clk);
    end
    n_checks++; if (bad != 0) $display("FAIL oor_ready_count got=%0d exp=0", bad); else n_pass++;
    in_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (err_sel !== 1'b0 || err_cnt !== 8'd255) $display("FAIL oor_idle got=%b/%0d exp=0/255", err_sel, err_cnt); else n_pass++;
    @(negedge clk);
    in_valid = 1'b1; in_bcast = 1'b1; in_sel = 2'd3; in_data = 8'h99;
    @(posedge clk); #1;
    n_checks++; if (err_sel !== 1'b0 || err_cnt !== 8'd255 || out_data !== 24'h999999) $display("FAIL oor_bcast got=%b/%0d/%h exp=0/255/999999", err_sel, err_cnt, out_data); else n_pass++;
    @(negedge clk);
    in_valid = 1'b0; in_bcast = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_drain_refill();
    @(negedge clk);
    out_ready = 3'b101;
    in_valid  = 1'b1; in_sel = 2'd1; in_data = 8'h66;
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 3'b010 || out_data !== 24'h006600) $display("FAIL dr_fill got=%b/%h exp=010/006600", out_valid, out_data); else n_pass++;
    @(negedge clk);
    out_ready = 3'b111; in_data = 8'h77;
    #1;
    n_checks++; if (in_ready !== 1'b1 || out_valid[1] !== 1'b1) $display("FAIL dr_ready got=%b/%b exp=1/1", in_ready, out_valid[1]); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 3'b010 || out_data !== 24'h007700) $display("FAIL dr_refill got=%b/%h exp=010/007700", out_valid, out_data); else n_pass++;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    out_ready = 3'b000;
    in_valid  = 1'b1; in_bcast = 1'b1; in_data = 8'hEE;
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 3'b111 || out_data !== 24'hEEEEEE) $display("FAIL ar_full got=%b/%h exp=111/eeeeee", out_valid, out_data); else n_pass++;
    in_valid = 1'b0; in_bcast = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 3'b000 || out_data !== 24'h0) $display("FAIL ar_clear got=%b/%h exp=000/000000", out_valid, out_data); else n_pass++;
    n_checks++; if (err_cnt !== 8'd0 || err_sel !== 1'b0 || in_ready !== 1'b0) $display("FAIL ar_err got=%0d/%b/%b exp=0/0/0", err_cnt, err_sel, in_ready); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h42;
    #1;
    n_checks++; if (out_valid !== 3'b000 || out_data !== 24'h0) $display("FAIL ar_stale got=%b/%h exp=000/000000", out_valid, out_data); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 3'b001 || out_data !== 24'h000042) $display("FAIL ar_first got=%b/%h exp=001/000042", out_valid, out_data); else n_pass++;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    in_data  = 8'h00;
    in_sel   = 2'd0;
    in_bcast = 1'b0;
    in_valid = 1'b0;
    out_ready = 3'b000;
    test_reset();
    test_unicast();
    test_backpressure();
    test_broadcast();
    test_out_of_range();
    test_drain_refill();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/demux_stream.md
DEMUX_STREAM -- requirements
Module: demux_stream

Interface
REQ-001 Parameter WIDTH, default 8: payload width in bits, legal range 1..64.
REQ-002 Parameter CHANNELS, default 4: number of output channels, legal range 2..16.
REQ-003 Parameter SEL_W, default 2: select width; SHALL equal ceil(log2(CHANNELS)); an elaboration check SHALL fail otherwise.
REQ-004 clk  input  1: single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1: reset, asynchronous assert, active-low.
REQ-006 in_data  input  WIDTH: input payload.
REQ-007 in_sel  input  SEL_W: destination channel index.
REQ-008 in_bcast  input  1: broadcast mode; when high, in_sel is ignored and the word goes to all channels.
REQ-009 in_valid  input  1: input word present.
REQ-010 in_ready  output  1: block accepts the word this cycle.
REQ-011 out_data  output  CHANNELS*WIDTH: channel c occupies bits [c*WIDTH +: WIDTH].
REQ-012 out_valid  output  CHANNELS: per-channel word present.
REQ-013 out_ready  input  CHANNELS: per-channel consumer ready.
REQ-014 err_sel  output  1: one-cycle pulse on acceptance of a unicast word with in_sel >= CHANNELS.
REQ-015 err_cnt  output  8: saturating count of out-of-range words.

Function
REQ-016 Each channel SHALL hold exactly one entry (slot); a slot is full when out_valid[c]=1.
REQ-017 Slot c is free when out_valid[c]=0 or out_ready[c]=1 (drain-and-refill in the same cycle allowed).
REQ-018 Unicast: in_ready = slot in_sel free; out-of-range in_sel: in_ready=1.
REQ-019 Broadcast: in_ready = all slots free.
REQ-020 in_ready SHALL be combinational from in_sel, in_bcast, out_valid and out_ready, with no dependence on in_valid.
REQ-021 A word is accepted on a rising edge with in_valid=1 and in_ready=1.
REQ-022 Latency: a word accepted at edge k SHALL appear on out_data/out_valid immediately after edge k (1 cycle).
REQ-023 A channel hand-off completes on an edge with out_valid[c]=1 and out_ready[c]=1.
REQ-024 On hand-off without refill, out_valid[c] SHALL go 0 and the out_data channel field SHALL go to all-zero; an idle channel always shows zero data.
REQ-025 On hand-off with simultaneous refill, out_valid[c] SHALL stay 1 and the data SHALL update to the new word.
REQ-026 A full slot without out_ready SHALL hold its data and valid unchanged (no overwrite, no loss).
REQ-027 Out-of-range unicast words SHALL be accepted and discarded; err_sel=1 for the cycle after acceptance; err_cnt increments, saturating at 255.
REQ-028 Broadcast SHALL NOT assert err_sel, regardless of in_sel.
REQ-029 Words to the same channel SHALL leave in acceptance order; there is no ordering between channels.

Reset
REQ-030 rst_n=0 SHALL immediately clear out_valid to 0, out_data to 0, err_sel to 0 and err_cnt to 0, independent of clk.
REQ-031 Reset mid-transfer SHALL discard all held words; no output appears after deassertion until a new acceptance.
REQ-032 While rst_n=0, in_ready SHALL be 0.
REQ-033 The first acceptance is possible on the first rising edge after rst_n rises.

Structure
REQ-034 Package demux_pkg SHALL hold the default WIDTH/CHANNELS constants, the ERR_CNT_W=8 constant and a clog2 function.
REQ-035 Sub-module demux_slot (one-entry holding register with load/drain/zero-on-empty) SHALL be instantiated once per channel by a generate loop.
REQ-036 The top level SHALL contain only ready/select decode and error counting.

Verification (WIDTH=8, CHANNELS=3, SEL_W=2)
REQ-037 Unicast: out_ready=3'b111; send 0xA5 sel=1 -> out_valid=3'b010 and ch1 data=0xA5 one cycle later, ch0/ch2 data=0x00.
REQ-038 Backpressure: out_ready[0]=0; send 0x11 then 0x22 to sel=0 -> in_ready=0 on second word; ch0 holds 0x11; raise out_ready[0] -> 0x22 follows, no loss.
REQ-039 Broadcast: ch2 full with out_ready[2]=0; send 0x3C with bcast -> in_ready=0; release ch2 -> all three channels show 0x3C, out_valid=3'b111.
REQ-040 Out-of-range: send sel=3 for 300 words -> each accepted, err_sel pulses, err_cnt saturates at 255, out_valid stays 0.
REQ-041 Same-cycle drain/refill: ch1 full and out_ready[1]=1, send 0x77 sel=1 -> out_valid[1] continuously 1, data 0x77 next cycle.
REQ-042 Async reset: with all channels full, pulse rst_n low between edges -> outputs and err_cnt zero immediately; no stale data after release.
